fb_access_scheduler: RTL

Schedules all accesses to the single-port framebuffer RAM (12-bit RGB444 pixels, 640x480 = 307200 words) behind the VGA scan-out logic. Display pixel fetches get absolute priority with fixed latency; writes from a drawing/host port are buffered and issued only in RAM cycles the display does not claim. The block sits between the display timing core, the pixel writer, and the framebuffer RAM, which has one-cycle registered read latency.

---
 rtl/fb_access_scheduler.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fb_access_scheduler.sv
// fb_access_scheduler: arbitrates the single-port framebuffer RAM between
// display pixel fetches (absolute priority, fixed 3-cycle latency) and
// buffered writes from the drawing/host port.
// Optional feature macro: FB_WR_FIFO_EN -- when defined, writes are held in a
// FIFO_DEPTH-entry FIFO; when undefined, a write is only accepted in a cycle
// without a display request and goes to the RAM on the next cycle.
module fb_access_scheduler #(
    parameter int AW         = 19,
    parameter int DW         = 12,
    parameter int FB_WORDS   = 307200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic [DW-1:0] disp_data,
    output logic          disp_valid,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_oob,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [AW:0] FB_LIMIT = (AW+1)'(FB_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } slot_e;

    // The FIFO pointers wrap by overflow, so the depth must be a power of two >= 2.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_fifo_depth_not_pow2
    end

    slot_e         state_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          wr_oob_q;
    logic          fetch_v1_q, fetch_hit1_q, fetch_v2_q, fetch_hit2_q;
    logic          disp_valid_q;
    logic [DW-1:0] disp_data_q;

    logic          rd_grant;
    logic          wr_in_range;
    logic          wr_accept;
    logic          wr_push;
    logic          wr_pending;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;

    // Out-of-range fetches take no RAM slot; out-of-range writes are accepted then dropped.
    assign rd_grant    = disp_req && ({1'b0, disp_addr} < FB_LIMIT);
    assign wr_in_range = ({1'b0, wr_addr} < FB_LIMIT);
    assign wr_accept   = wr_valid && wr_ready;
    assign wr_push     = wr_accept && wr_in_range;

`ifdef FB_WR_FIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [AW-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DW-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [PW:0]   count_q, count_d;
    logic          full_q;
    logic          fifo_empty, fifo_push, fifo_pop;

    // Head selection: an empty FIFO lets a newly accepted write bypass straight to the RAM slot.
    always_comb begin
        fifo_empty = (count_q == '0);
        wr_pending = !fifo_empty || wr_push;
        head_addr  = fifo_empty ? wr_addr : fifo_addr_q[rd_ptr_q];
        head_data  = fifo_empty ? wr_data : fifo_data_q[rd_ptr_q];
        fifo_pop   = !rd_grant && !fifo_empty;
        fifo_push  = wr_push && !(fifo_empty && !rd_grant);
        count_d    = count_q + (PW+1)'(fifo_push) - (PW+1)'(fifo_pop);
    end

    assign wr_ready = !full_q && !rst;

    // FIFO bookkeeping: pointers, occupancy and a registered full flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (fifo_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            full_q  <= (count_d == (PW+1)'(FIFO_DEPTH));
        end
    end

    // FIFO storage; contents need no reset because occupancy guards every read.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_addr_q[wr_ptr_q] <= wr_addr;
            fifo_data_q[wr_ptr_q] <= wr_data;
        end
    end
`else
    // Unbuffered: a write is taken only when no fetch competes, so it always wins the next slot.
    assign wr_ready   = !disp_req && !rst;
    assign wr_pending = wr_push;
    assign head_addr  = wr_addr;
    assign head_data  = wr_data;
`endif

    // Slot FSM: fetch first, then a pending write, else idle with the bus holding its last values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wr_oob_q    <= 1'b0;
        end else begin
            wr_oob_q <= wr_accept && !wr_in_range;
            if (rd_grant) begin
                state_q    <= S_RD;
                mem_addr_q <= disp_addr;
            end else if (wr_pending) begin
                state_q     <= S_WR;
                mem_addr_q  <= head_addr;
                mem_wdata_q <= head_data;
            end else begin
                state_q <= S_IDLE;
            end
        end
    end

    // Fetch pipeline: request -> RAM slot -> RAM data -> registered pixel, out-of-range reads give 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_v1_q   <= 1'b0;
            fetch_hit1_q <= 1'b0;
            fetch_v2_q   <= 1'b0;
            fetch_hit2_q <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
        end else begin
            fetch_v1_q   <= disp_req;
            fetch_hit1_q <= rd_grant;
            fetch_v2_q   <= fetch_v1_q;
            fetch_hit2_q <= fetch_hit1_q;
            disp_valid_q <= fetch_v2_q;
            if (fetch_v2_q) disp_data_q <= fetch_hit2_q ? mem_rdata : '0;
        end
    end

    assign mem_en     = (state_q != S_IDLE);
    assign mem_we     = (state_q == S_WR);
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign wr_oob     = wr_oob_q;
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;

endmodule
